// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with a fully registered in_ready.
// Optional synchronous flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef PIPE_SKID_FLUSH_EN
    // A redirect discards everything held, including the word offered this cycle.
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
    end
`endif
    // Handshake flags are registered from the next state so no comb path reaches upstream.
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard testbench for pipe_skid_reg; flush scenario runs when PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid_reg;

  localparam int          W      = 32;
  localparam logic [31:0] RV     = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    count;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [W-1:0]  s_out_data;
  logic [1:0]    s_count;

  logic [W-1:0]  sb[$];
  int            compared   = 0;
  int            mismatched = 0;

  pipe_skid_reg #(.DATA_WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs after the falling edge, sample outputs, then wait for the rising edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, input logic rs);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst       = rs;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_count     = count;
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h1234, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h1234, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    compared += 4;
    if (s_out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", s_out_valid);
    end
    if (s_in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", s_in_ready);
    end
    if (s_count !== 2'd0) begin
      mismatched++; $display("[TB] FAIL reset_count got %0d want 0", s_count);
    end
    if (s_out_data !== RV) begin
      mismatched++; $display("[TB] FAIL reset_out_data got %h want %h", s_out_data, RV);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] src[$];
    logic [W-1:0] exp;
    logic         v;
    int           outs = 0;
    src = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 4; i++) begin
      v = (src.size() > 0);
      drive(v, v ? src[0] : 32'h0, 1'b1, 1'b0, 1'b0);
      if (i >= 1) begin
        compared++;
        if (s_count !== 2'd1) begin
          mismatched++; $display("[TB] FAIL b2b_count cycle %0d got %0d want 1", i, s_count);
        end
      end
      if (v && s_in_ready) sb.push_back(src.pop_front());
      if (s_out_valid) begin
        outs++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++; $display("[TB] FAIL b2b_unexpected got %h want none", s_out_data);
        end else begin
          exp = sb.pop_front();
          if (s_out_data !== exp) begin
            mismatched++; $display("[TB] FAIL b2b_data cycle %0d got %h want %h", i, s_out_data, exp);
          end
        end
      end
    end
    compared++;
    if (outs != 3) begin
      mismatched++; $display("[TB] FAIL b2b_outs got %0d want 3", outs);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] src[$];
    logic [W-1:0] exp;
    logic         v;
    logic         rdy;
    int           outs = 0;
    src = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 12; i++) begin
      v   = (src.size() > 0);
      rdy = (i >= 3);
      drive(v, v ? src[0] : 32'h0, rdy, 1'b0, 1'b0);
      if (i == 2) begin
        compared += 2;
        if (s_count !== 2'd2) begin
          mismatched++; $display("[TB] FAIL bp_count got %0d want 2", s_count);
        end
        if (s_in_ready !== 1'b0) begin
          mismatched++; $display("[TB] FAIL bp_in_ready got %b want 0", s_in_ready);
        end
      end
      if (v && s_in_ready) sb.push_back(src.pop_front());
      if (s_out_valid && rdy) begin
        outs++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++; $display("[TB] FAIL bp_unexpected got %h want none", s_out_data);
        end else begin
          exp = sb.pop_front();
          if (s_out_data !== exp) begin
            mismatched++; $display("[TB] FAIL bp_data got %h want %h", s_out_data, exp);
          end
        end
      end
    end
    compared += 2;
    if (outs != 3) begin
      mismatched++; $display("[TB] FAIL bp_outs got %0d want 3", outs);
    end
    if (sb.size() != 0 || src.size() != 0) begin
      mismatched++; $display("[TB] FAIL bp_drain got %0d/%0d left want 0/0", sb.size(), src.size());
    end
  endtask

  task automatic test_toggle_ready();
    logic [W-1:0] src[$];
    logic [W-1:0] exp;
    logic [W-1:0] held = '0;
    logic         hold_pending = 1'b0;
    logic         v;
    logic         rdy;
    int           outs = 0;
    for (int k = 0; k < 16; k++) src.push_back($urandom());
    for (int i = 0; i < 80; i++) begin
      v   = (src.size() > 0);
      rdy = (i < 2) ? 1'b0 : ((i < 50) ? 1'(i % 2) : 1'b1);
      drive(v, v ? src[0] : 32'h0, rdy, 1'b0, 1'b0);
      if (hold_pending && s_out_valid) begin
        compared++;
        if (s_out_data !== held) begin
          mismatched++; $display("[TB] FAIL tog_stable got %h want %h", s_out_data, held);
        end
      end
      hold_pending = s_out_valid && !rdy;
      held         = s_out_data;
      if (v && s_in_ready) sb.push_back(src.pop_front());
      if (s_out_valid && rdy) begin
        outs++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++; $display("[TB] FAIL tog_unexpected got %h want none", s_out_data);
        end else begin
          exp = sb.pop_front();
          if (s_out_data !== exp) begin
            mismatched++; $display("[TB] FAIL tog_data got %h want %h", s_out_data, exp);
          end
        end
      end
    end
    compared += 2;
    if (outs != 16) begin
      mismatched++; $display("[TB] FAIL tog_outs got %0d want 16", outs);
    end
    if (sb.size() != 0 || src.size() != 0) begin
      mismatched++; $display("[TB] FAIL tog_drain got %0d/%0d left want 0/0", sb.size(), src.size());
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h0101, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0202, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0777, 1'b0, 1'b0, 1'b1);
    compared++;
    if (s_count !== 2'd2) begin
      mismatched++; $display("[TB] FAIL rstmid_pre_count got %0d want 2", s_count);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    compared += 4;
    if (s_count !== 2'd0) begin
      mismatched++; $display("[TB] FAIL rstmid_count got %0d want 0", s_count);
    end
    if (s_out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL rstmid_out_valid got %b want 0", s_out_valid);
    end
    if (s_out_data !== RV) begin
      mismatched++; $display("[TB] FAIL rstmid_out_data got %h want %h", s_out_data, RV);
    end
    if (s_in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL rstmid_in_ready got %b want 1", s_in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      compared++;
      if (s_out_valid !== 1'b0) begin
        mismatched++; $display("[TB] FAIL rstmid_ghost got %h want no output", s_out_data);
      end
    end
    sb.delete();
  endtask

`ifdef PIPE_SKID_FLUSH_EN
  task automatic test_flush();
    drive(1'b1, 32'h0A0A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0B0B, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0055, 1'b0, 1'b1, 1'b0);
    compared++;
    if (s_count !== 2'd2) begin
      mismatched++; $display("[TB] FAIL flush_pre_count got %0d want 2", s_count);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    compared += 4;
    if (s_count !== 2'd0) begin
      mismatched++; $display("[TB] FAIL flush_count got %0d want 0", s_count);
    end
    if (s_in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL flush_in_ready got %b want 1", s_in_ready);
    end
    if (s_out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL flush_out_valid got %b want 0", s_out_valid);
    end
    if (s_out_data !== RV) begin
      mismatched++; $display("[TB] FAIL flush_out_data got %h want %h", s_out_data, RV);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      compared++;
      if (s_out_valid !== 1'b0) begin
        mismatched++; $display("[TB] FAIL flush_ghost got %h want no output", s_out_data);
      end
    end
    sb.delete();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_toggle_ready();
    test_reset_mid();
`ifdef PIPE_SKID_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
